delay_chain_calibrator: RTL

//  Sequencer that measures the inverter-chain delay lines used in the VGA test design.

---
 rtl/delay_chain_calibrator_if.sv | 50 +++++
 rtl/delay_chain_calibrator.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/delay_chain_calibrator_if.sv
`default_nettype none
// ============================================================================
// Module   : delay_chain_calibrator_if
// Brief    : Control, result and ring-mux signals of the delay-chain calibrator.
//            Optional min/max fields exist when DLYCAL_MINMAX_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface delay_chain_calibrator_if #(
    parameter int TAP_W = 3,
    parameter int CNT_W = 16
);
    logic             start;
    logic             abort;
    logic             ring_in;
    logic             ring_en;
    logic [TAP_W-1:0] tap_sel;
    logic             busy;
    logic             done;
    logic             result_valid;
    logic [TAP_W-1:0] result_tap;
    logic [CNT_W-1:0] result_count;
    logic             result_ovf;
`ifdef DLYCAL_MINMAX_EN
    logic [CNT_W-1:0] min_count;
    logic [CNT_W-1:0] max_count;
    logic [TAP_W-1:0] min_tap;
    logic [TAP_W-1:0] max_tap;
`endif

    // Calibrator side
    modport master (
        input  start, abort, ring_in,
        output ring_en, tap_sel, busy, done,
               result_valid, result_tap, result_count, result_ovf
`ifdef DLYCAL_MINMAX_EN
        , output min_count, max_count, min_tap, max_tap
`endif
    );

    // Controller / ring-mux side
    modport slave (
        output start, abort, ring_in,
        input  ring_en, tap_sel, busy, done,
               result_valid, result_tap, result_count, result_ovf
`ifdef DLYCAL_MINMAX_EN
        , input min_count, max_count, min_tap, max_tap
`endif
    );
endinterface
`default_nettype wire

// File: rtl/delay_chain_calibrator.sv
`default_nettype none
// ============================================================================
// Module   : delay_chain_calibrator
// Brief    : Sweeps the ring-oscillator tap select and counts ring edges per tap
//            over a fixed gate window. Macro DLYCAL_MINMAX_EN adds min/max tracking.
// Revision : 1.0 - initial release
// ============================================================================
module delay_chain_calibrator #(
    parameter int NUM_TAPS      = 8,
    parameter int TAP_W         = 3,
    parameter int CNT_W         = 16,
    parameter int GATE_CYCLES   = 1024,
    parameter int SETTLE_CYCLES = 16
) (
    input  wire logic                clk,
    input  wire logic                rst,
    delay_chain_calibrator_if.master bus
);
    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_SWITCH  = 3'd1;
    localparam logic [2:0] c_ST_SETTLE  = 3'd2;
    localparam logic [2:0] c_ST_MEASURE = 3'd3;
    localparam logic [2:0] c_ST_DONE    = 3'd4;

    localparam int c_PH_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int c_PH_W   = $clog2(c_PH_MAX + 1);
    localparam logic [c_PH_W-1:0] c_SETTLE_LAST = c_PH_W'(SETTLE_CYCLES - 1);
    localparam logic [c_PH_W-1:0] c_GATE_LAST   = c_PH_W'(GATE_CYCLES - 1);
    localparam logic [TAP_W-1:0]  c_LAST_TAP    = TAP_W'(NUM_TAPS - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic              r_sync1;
    logic              r_sync2;
    logic              r_prev;
    logic [c_PH_W-1:0] r_ph;
    logic [TAP_W-1:0]  r_tap;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              r_ovf;
    logic              w_ovf_nxt;
    logic              r_res_valid;
    logic [TAP_W-1:0]  r_res_tap;
    logic [CNT_W-1:0]  r_res_count;
    logic              r_res_ovf;
    logic              w_rise;
    logic              w_settle_last;
    logic              w_gate_last;
    logic              w_last_tap;
    logic              w_capture;
    logic              w_start_ok;
    logic              w_ring_en;
    logic              w_busy;
    logic              w_done;

    assign w_rise        = r_sync2 & ~r_prev;
    assign w_settle_last = (r_state == c_ST_SETTLE) && (r_ph == c_SETTLE_LAST);
    assign w_gate_last   = (r_state == c_ST_MEASURE) && (r_ph == c_GATE_LAST);
    assign w_last_tap    = (r_tap == c_LAST_TAP);
    assign w_capture     = w_gate_last && !bus.abort;
    assign w_start_ok    = (r_state == c_ST_IDLE) && bus.start && !bus.abort;
    // Saturating count; ovf marks an edge that arrived with the counter already full
    assign w_count_nxt   = (w_rise && !(&r_count)) ? r_count + 1'b1 : r_count;
    assign w_ovf_nxt     = r_ovf | (w_rise & (&r_count));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.abort) begin
            w_state_nxt = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE:    if (bus.start) w_state_nxt = c_ST_SWITCH;
                c_ST_SWITCH:  w_state_nxt = c_ST_SETTLE;
                c_ST_SETTLE:  if (w_settle_last) w_state_nxt = c_ST_MEASURE;
                c_ST_MEASURE: if (w_gate_last) w_state_nxt = w_last_tap ? c_ST_DONE : c_ST_SWITCH;
                c_ST_DONE:    w_state_nxt = c_ST_IDLE;
                default:      w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_ring_en = 1'b0;
        w_busy    = 1'b1;
        w_done    = 1'b0;
        case (r_state)
            c_ST_IDLE:                 w_busy    = 1'b0;
            c_ST_SETTLE, c_ST_MEASURE: w_ring_en = 1'b1;
            c_ST_DONE:                 w_done    = 1'b1;
            default:                   ;
        endcase
    end

    // Two-flop synchroniser; prev is forced low while the mux switches taps
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= bus.ring_in;
            r_sync2 <= r_sync1;
            r_prev  <= (r_state == c_ST_SWITCH) ? 1'b0 : r_sync2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tap   <= '0;
            r_ph    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (bus.abort) begin
            r_tap <= '0;
            r_ph  <= '0;
        end else begin
            case (r_state)
                c_ST_SWITCH: begin
                    r_ph    <= '0;
                    r_count <= '0;
                    r_ovf   <= 1'b0;
                end
                c_ST_SETTLE: r_ph <= w_settle_last ? '0 : r_ph + 1'b1;
                c_ST_MEASURE: begin
                    r_count <= w_count_nxt;
                    r_ovf   <= w_ovf_nxt;
                    r_ph    <= r_ph + 1'b1;
                    if (w_gate_last) begin
                        r_tap <= w_last_tap ? '0 : r_tap + 1'b1;
                    end
                end
                default: r_tap <= '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid <= 1'b0;
            r_res_tap   <= '0;
            r_res_count <= '0;
            r_res_ovf   <= 1'b0;
        end else begin
            r_res_valid <= w_capture;
            if (w_capture) begin
                r_res_tap   <= r_tap;
                r_res_count <= w_count_nxt;
                r_res_ovf   <= w_ovf_nxt;
            end
        end
    end

    assign bus.ring_en      = w_ring_en;
    assign bus.tap_sel      = r_tap;
    assign bus.busy         = w_busy;
    assign bus.done         = w_done;
    assign bus.result_valid = r_res_valid;
    assign bus.result_tap   = r_res_tap;
    assign bus.result_count = r_res_count;
    assign bus.result_ovf   = r_res_ovf;

`ifdef DLYCAL_MINMAX_EN
    logic [CNT_W-1:0] r_min_count;
    logic [CNT_W-1:0] r_max_count;
    logic [TAP_W-1:0] r_min_tap;
    logic [TAP_W-1:0] r_max_tap;

    // Updated alongside the result capture so the final tap is included when done pulses
    always_ff @(posedge clk) begin
        if (rst || w_start_ok) begin
            r_min_count <= '0;
            r_max_count <= '0;
            r_min_tap   <= '0;
            r_max_tap   <= '0;
        end else if (w_capture) begin
            if ((r_tap == '0) || (w_count_nxt < r_min_count)) begin
                r_min_count <= w_count_nxt;
                r_min_tap   <= r_tap;
            end
            if ((r_tap == '0) || (w_count_nxt > r_max_count)) begin
                r_max_count <= w_count_nxt;
                r_max_tap   <= r_tap;
            end
        end
    end

    assign bus.min_count = r_min_count;
    assign bus.max_count = r_max_count;
    assign bus.min_tap   = r_min_tap;
    assign bus.max_tap   = r_max_tap;
`endif
endmodule
`default_nettype wire
